mem_port_arbiter: RTL and testbench

Two-master arbiter that shares the single SRAM-like memory port between the instruction-fetch requester (m0) and the data requester (m1, driven by the MEM-stage request mux). It forwards one request per handshake, locks the grant while a request waits for `addr_ok`, and tracks outstanding transactions in an owner FIFO so `data_ok` and `rdata` return to the issuing master in order. It sits between the CPU core and the cache/bridge port.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a shared SRAM-like port: one request forwarded per handshake,
// grant locked until addr_ok, and an owner FIFO that routes data_ok back in issue order.
module mem_port_arbiter #(
    parameter int MAX_OUT    = 4,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_rdata,

    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,

    output logic        err_spurious
);

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIM + 1);

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [MAX_OUT-1:0] owner_mem;

    logic               locked;
    logic               lock_owner;
    logic [STV_W-1:0]   starve_cnt;
    logic               err_q;

    logic               fifo_empty;
    logic               full;
    logic               starved;
    logic               pop;
    logic               push;
    logic               accept;
    logic               gnt_vld;
    logic               gnt_id;
    logic               sel_req;
    logic               head_id;

    assign fifo_empty = (count == '0);
    assign full       = (count == CNT_W'(MAX_OUT));
    assign starved    = (starve_cnt == STV_W'(STARVE_LIM));
    assign pop        = s_data_ok && !fifo_empty;

    // A pop in the same cycle frees a slot, so a full FIFO still admits a request then.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (locked) begin
            gnt_vld = 1'b1;
            gnt_id  = lock_owner;
        end else if (full && !pop) begin
            gnt_vld = 1'b0;
        end else if (m0_req && m1_req) begin
            gnt_vld = 1'b1;
            gnt_id  = !starved;
        end else if (m1_req) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
        end else if (m0_req) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
        end
    end

    // Master inputs are live during reset, so the forwarded request is gated explicitly.
    assign sel_req = gnt_id ? m1_req : m0_req;
    assign s_req   = resetn && gnt_vld && sel_req;
    assign s_wr    = gnt_id ? m1_wr    : m0_wr;
    assign s_size  = gnt_id ? m1_size  : m0_size;
    assign s_addr  = gnt_id ? m1_addr  : m0_addr;
    assign s_wstrb = gnt_id ? m1_wstrb : m0_wstrb;
    assign s_wdata = gnt_id ? m1_wdata : m0_wdata;

    assign accept     = s_req && s_addr_ok;
    assign push       = accept;
    assign m0_addr_ok = accept && !gnt_id;
    assign m1_addr_ok = accept &&  gnt_id;

    assign head_id    = owner_mem[rd_ptr];
    assign m0_data_ok = pop && !head_id;
    assign m1_data_ok = pop &&  head_id;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

    assign err_spurious = err_q;

    // Owner ids are payload only; validity comes from count, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            owner_mem[wr_ptr] <= gnt_id;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            locked     <= 1'b0;
            lock_owner <= 1'b0;
        end else if (accept) begin
            locked     <= 1'b0;
        end else if (s_req) begin
            locked     <= 1'b1;
            lock_owner <= gnt_id;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (!m0_req || (accept && !gnt_id)) begin
            starve_cnt <= '0;
        end else if (accept && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (s_data_ok && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural model predicts grants per cycle and
// queues expected owners; an independent monitor checks every data_ok against that queue.
module tb_mem_port_arbiter;

    localparam int MAX_OUT    = 4;
    localparam int STARVE_LIM = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        mreq   [2];
    logic        mwr    [2];
    logic [1:0]  msize  [2];
    logic [31:0] maddr  [2];
    logic [3:0]  mwstrb [2];
    logic [31:0] mwdata [2];

    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_addr_ok = 1'b0;
    logic        s_data_ok = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        err_spurious;

    mem_port_arbiter #(.MAX_OUT(MAX_OUT), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(mreq[0]), .m0_wr(mwr[0]), .m0_size(msize[0]), .m0_addr(maddr[0]),
        .m0_wstrb(mwstrb[0]), .m0_wdata(mwdata[0]),
        .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(mreq[1]), .m1_wr(mwr[1]), .m1_size(msize[1]), .m1_addr(maddr[1]),
        .m1_wstrb(mwstrb[1]), .m1_wdata(mwdata[1]),
        .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wstrb(s_wstrb), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: plain counters, no knowledge of pointers or encodings.
    int  md_out    = 0;
    bit  md_lock   = 0;
    int  md_owner  = 0;
    int  md_starve = 0;
    bit  md_err    = 0;
    int  exp_q[$];

    int          obs_g;
    logic        obs_sreq;
    logic [31:0] obs_addr;
    logic [1:0]  obs_dok;
    logic [31:0] obs_rdata;
    logic        obs_err;
    int          last_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic new_fields(input int i);
        mwr[i]    = 1'($urandom_range(0, 1));
        msize[i]  = 2'($urandom_range(0, 2));
        maddr[i]  = $urandom;
        mwstrb[i] = 4'($urandom);
        mwdata[i] = $urandom;
    endtask

    task automatic model_reset();
        md_out = 0; md_lock = 0; md_owner = 0; md_starve = 0; md_err = 0;
        exp_q.delete();
    endtask

    // One clock cycle with the current inputs: predict, compare, then advance the model.
    task automatic step();
        int g;
        bit acc, pop;
        #1;
        if (md_lock)                               g = md_owner;
        else if (md_out == MAX_OUT && !s_data_ok)  g = -1;
        else if (mreq[0] && mreq[1])               g = (md_starve == STARVE_LIM) ? 0 : 1;
        else if (mreq[1])                          g = 1;
        else if (mreq[0])                          g = 0;
        else                                       g = -1;
        acc = (g >= 0) && s_addr_ok;
        pop = s_data_ok && (md_out > 0);

        chk("s_req", {31'b0, s_req}, {31'b0, g >= 0});
        chk("m0_addr_ok", {31'b0, m0_addr_ok}, {31'b0, acc && g == 0});
        chk("m1_addr_ok", {31'b0, m1_addr_ok}, {31'b0, acc && g == 1});
        if (g >= 0) begin
            chk("s_addr", s_addr, maddr[g]);
            chk("s_fields", {s_wr, s_size, s_wstrb}, {mwr[g], msize[g], mwstrb[g]});
            chk("s_wdata", s_wdata, mwdata[g]);
        end
        chk("data_ok_any", {31'b0, m0_data_ok | m1_data_ok}, {31'b0, pop});
        chk("err_spurious", {31'b0, err_spurious}, {31'b0, md_err});

        obs_g     = m0_addr_ok ? 0 : (m1_addr_ok ? 1 : -1);
        obs_sreq  = s_req;
        obs_addr  = s_addr;
        obs_dok   = {m1_data_ok, m0_data_ok};
        obs_rdata = m1_data_ok ? m1_rdata : m0_rdata;
        obs_err   = err_spurious;
        if (acc) exp_q.push_back(g);
        last_acc = acc ? g : -1;

        @(posedge clk);
        #1;
        if (s_data_ok && md_out == 0) md_err = 1;
        if (acc) begin
            md_lock = 0;
            md_out++;
        end else if (g >= 0) begin
            md_lock  = 1;
            md_owner = g;
        end
        if (pop) md_out--;
        if (!mreq[0] || (acc && g == 0)) md_starve = 0;
        else if (acc && g == 1 && md_starve < STARVE_LIM) md_starve++;
    endtask

    task automatic drain();
        mreq[0] = 0; mreq[1] = 0; s_addr_ok = 0;
        for (int k = 0; k < 8 && md_out > 0; k++) begin
            s_data_ok = 1; s_rdata = $urandom;
            step();
        end
        s_data_ok = 0;
    endtask

    // Monitor: decoupled from stimulus, pops the scoreboard on every observed data_ok.
    always @(negedge clk) begin
        int e;
        if (resetn && (m0_data_ok || m1_data_ok)) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL data_ok_unexpected: got %b expected none", {m1_data_ok, m0_data_ok});
            end else begin
                e = exp_q.pop_front();
                chk("data_ok_owner", {30'b0, m1_data_ok, m0_data_ok}, (e == 0) ? 32'd1 : 32'd2);
                chk("rdata", (e == 0) ? m0_rdata : m1_rdata, s_rdata);
            end
        end
    end

    initial begin
        int exp2[9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
        for (int i = 0; i < 2; i++) begin
            mreq[i] = 0;
            new_fields(i);
        end

        // Held in reset: nothing may be forwarded or acknowledged.
        mreq[1] = 1; s_addr_ok = 1; s_data_ok = 1; s_rdata = 32'h1234_5678;
        #3;
        chk("rst_s_req", {31'b0, s_req}, 32'd0);
        chk("rst_m1_addr_ok", {31'b0, m1_addr_ok}, 32'd0);
        chk("rst_data_ok", {30'b0, m1_data_ok, m0_data_ok}, 32'd0);
        chk("rst_rdata", m1_rdata, 32'h1234_5678);
        chk("rst_err", {31'b0, err_spurious}, 32'd0);
        mreq[1] = 0; s_addr_ok = 0; s_data_ok = 0;
        @(posedge clk); @(posedge clk); #1;
        resetn = 1;
        model_reset();

        // Idle to single request and its response two cycles later.
        mreq[1] = 1; maddr[1] = 32'h1000; s_addr_ok = 1;
        step();
        chk("t1_accept", obs_g, 32'd1);
        chk("t1_s_addr", obs_addr, 32'h1000);
        mreq[1] = 0; s_addr_ok = 0;
        step();
        s_data_ok = 1; s_rdata = 32'hDEAD_BEEF;
        step();
        chk("t1_dok", {30'b0, obs_dok}, 32'd2);
        chk("t1_rdata", obs_rdata, 32'hDEAD_BEEF);
        s_data_ok = 0;

        // Both masters continuously requesting with an always-ready slave.
        mreq[0] = 1; mreq[1] = 1; s_addr_ok = 1;
        for (int k = 0; k < 9; k++) begin
            s_data_ok = (md_out > 0); s_rdata = $urandom;
            step();
            chk($sformatf("t2_grant%0d", k), obs_g, exp2[k]);
            if (obs_g >= 0) new_fields(obs_g);
        end
        drain();

        // Lock: m0 waits on addr_ok while m1 joins; m1 only after m0 is accepted.
        mreq[0] = 1; maddr[0] = 32'hA000; s_addr_ok = 0;
        step();
        chk("t3_addr_c0", obs_addr, 32'hA000);
        mreq[1] = 1; maddr[1] = 32'hB000;
        for (int k = 1; k < 3; k++) begin
            step();
            chk($sformatf("t3_addr_c%0d", k), obs_addr, 32'hA000);
        end
        s_addr_ok = 1;
        step();
        chk("t3_accept_m0", obs_g, 32'd0);
        mreq[0] = 0;
        step();
        chk("t3_accept_m1", obs_g, 32'd1);
        chk("t3_addr_m1", obs_addr, 32'hB000);
        drain();

        // FIFO full: fifth request is held off until a data_ok frees a slot.
        mreq[0] = 1; s_addr_ok = 1; s_data_ok = 0;
        for (int k = 0; k < 4; k++) begin
            new_fields(0);
            step();
            chk($sformatf("t4_fill%0d", k), obs_g, 32'd0);
        end
        new_fields(0);
        step();
        chk("t4_full_sreq", {31'b0, obs_sreq}, 32'd0);
        s_data_ok = 1; s_rdata = $urandom;
        step();
        chk("t4_pop_accept", obs_g, 32'd0);
        s_data_ok = 0; new_fields(0);
        step();
        chk("t4_still_full", {31'b0, obs_sreq}, 32'd0);
        drain();

        // In-order routing, then a spurious response.
        s_addr_ok = 1;
        for (int k = 0; k < 3; k++) begin
            mreq[k % 2] = 1; new_fields(k % 2);
            step();
            mreq[k % 2] = 0;
        end
        s_addr_ok = 0;
        for (int k = 0; k < 3; k++) begin
            s_data_ok = 1; s_rdata = $urandom;
            step();
            chk($sformatf("t5_dok%0d", k), {30'b0, obs_dok}, (k == 1) ? 32'd2 : 32'd1);
        end
        step();
        chk("t5_spurious_dok", {30'b0, obs_dok}, 32'd0);
        s_data_ok = 0;
        step();
        chk("t5_err", {31'b0, obs_err}, 32'd1);

        // Asynchronous reset with two outstanding requests.
        mreq[1] = 1; s_addr_ok = 1;
        step(); new_fields(1);
        step(); new_fields(1);
        #2;
        resetn = 0;
        #1;
        chk("t6_s_req", {31'b0, s_req}, 32'd0);
        chk("t6_addr_ok", {30'b0, m1_addr_ok, m0_addr_ok}, 32'd0);
        s_data_ok = 1; s_rdata = 32'hCAFE_F00D;
        #1;
        chk("t6_data_ok", {30'b0, m1_data_ok, m0_data_ok}, 32'd0);
        chk("t6_rdata", m1_rdata, 32'hCAFE_F00D);
        chk("t6_err", {31'b0, err_spurious}, 32'd0);
        model_reset();
        mreq[1] = 0; s_addr_ok = 0; s_data_ok = 0;
        @(posedge clk); #1;
        resetn = 1;
        mreq[0] = 1; new_fields(0); s_addr_ok = 1;
        step();
        chk("t6_fresh_accept", obs_g, 32'd0);
        mreq[0] = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = $urandom;
        step();
        chk("t6_fresh_dok", {30'b0, obs_dok}, 32'd1);
        s_data_ok = 0;

        // Randomized traffic against the model and scoreboard.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!mreq[i] && $urandom_range(0, 1) == 1) begin
                    mreq[i] = 1;
                    new_fields(i);
                end
            end
            s_addr_ok = ($urandom_range(0, 3) != 0);
            s_data_ok = (md_out > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 49) == 0);
            s_rdata   = $urandom;
            step();
            if (last_acc >= 0) mreq[last_acc] = 0;
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
